// File: rtl/core_rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter and its scoreboard.
package core_pkg;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    SRC_MD  = 1'b0,
    SRC_DMA = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MD,
    GNT_DMA
  } grant_e;
endpackage

// File: rtl/core_rf_wb_arbiter_if.sv
// Bundle of issue, ID, writeback-source and register-file signals around the arbiter.
interface core_rf_wb_arbiter_if #(parameter int unsigned XLEN = 32);
  logic            iss_valid_i;
  logic            iss_src_i;
  logic [4:0]      iss_rd_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic [4:0]      id_rd_i;
  logic            hazard_o;
  logic            wb_reg_write_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_din_i;
  logic            md_valid_i;
  logic [4:0]      md_rd_i;
  logic [XLEN-1:0] md_din_i;
  logic            md_ready_o;
  logic            dma_valid_i;
  logic [4:0]      dma_rd_i;
  logic [XLEN-1:0] dma_din_i;
  logic            dma_ready_o;
  logic            rf_we_o;
  logic [4:0]      rf_rd_o;
  logic [XLEN-1:0] rf_din_o;
  logic            bubble_req_o;
  logic [31:0]     pending_o;
  logic            wb_conflict_o;

  modport slave (
    input  iss_valid_i, iss_src_i, iss_rd_i, id_rs1_i, id_rs2_i, id_rd_i,
    input  wb_reg_write_i, wb_rd_i, wb_din_i,
    input  md_valid_i, md_rd_i, md_din_i, dma_valid_i, dma_rd_i, dma_din_i,
    output hazard_o, md_ready_o, dma_ready_o, rf_we_o, rf_rd_o, rf_din_o,
    output bubble_req_o, pending_o, wb_conflict_o
  );

  modport master (
    output iss_valid_i, iss_src_i, iss_rd_i, id_rs1_i, id_rs2_i, id_rd_i,
    output wb_reg_write_i, wb_rd_i, wb_din_i,
    output md_valid_i, md_rd_i, md_din_i, dma_valid_i, dma_rd_i, dma_din_i,
    input  hazard_o, md_ready_o, dma_ready_o, rf_we_o, rf_rd_o, rf_din_o,
    input  bubble_req_o, pending_o, wb_conflict_o
  );
endinterface

// File: rtl/core_rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for long-latency destinations and the ID hazard lookup.
module core_scoreboard
  import core_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_en,
  input  logic [4:0]          set_rd,
  input  logic                clr_en,
  input  logic [4:0]          clr_rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [4:0]          rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                hazard
);
  logic [NUM_REGS-1:0] pending_next;

  // Clear applied before set so a same-cycle issue to the retiring rd stays pending.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_rd] = 1'b0;
    if (set_en) pending_next[set_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending <= '0;
    else         pending <= pending_next;
  end

  assign hazard = pending[rs1] | pending[rs2] | pending[rd];
endmodule

// File: rtl/core_rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, then round-robin
// between mul/div and DMA, with starvation relief and a pending-write scoreboard.
module core_rf_wb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  core_rf_wb_arbiter_if.slave  bus
);
  grant_e              gnt;
  src_e                ptr;
  logic [4:0]          sel_rd;
  logic [XLEN-1:0]     sel_din;
  logic                long_gnt;
  logic                blocked;
  logic [2:0]          starve_cnt;
  logic [2:0]          starve_next;
  logic                bubble;
  logic                rf_we;
  logic [4:0]          rf_rd;
  logic [XLEN-1:0]     rf_din;
  logic                conflict;
  logic [NUM_REGS-1:0] pending;
  logic                hazard;
  logic                unused_src;

  assign unused_src = bus.iss_src_i;

  // Grant is gated by reset so an in-flight handshake is dropped immediately.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_ni)                             gnt = GNT_NONE;
    else if (bus.wb_reg_write_i)             gnt = GNT_WB;
    else if (bus.md_valid_i && bus.dma_valid_i)
      gnt = (ptr == SRC_MD) ? GNT_MD : GNT_DMA;
    else if (bus.md_valid_i)                 gnt = GNT_MD;
    else if (bus.dma_valid_i)                gnt = GNT_DMA;
  end

  always_comb begin
    sel_rd  = '0;
    sel_din = '0;
    case (gnt)
      GNT_WB:  begin sel_rd = bus.wb_rd_i;  sel_din = bus.wb_din_i;  end
      GNT_MD:  begin sel_rd = bus.md_rd_i;  sel_din = bus.md_din_i;  end
      GNT_DMA: begin sel_rd = bus.dma_rd_i; sel_din = bus.dma_din_i; end
      default: ;
    endcase
  end

  assign long_gnt = (gnt == GNT_MD) || (gnt == GNT_DMA);
  assign blocked  = bus.wb_reg_write_i && (bus.md_valid_i || bus.dma_valid_i);

  always_comb begin
    starve_next = starve_cnt;
    if (long_gnt)                          starve_next = '0;
    else if (blocked && starve_cnt != '1)  starve_next = starve_cnt + 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_din     <= '0;
      ptr        <= SRC_MD;
      starve_cnt <= '0;
      bubble     <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      rf_we <= (gnt != GNT_NONE) && (sel_rd != '0);
      if (gnt != GNT_NONE) begin
        rf_rd  <= sel_rd;
        rf_din <= sel_din;
      end
      if (long_gnt) ptr <= (gnt == GNT_MD) ? SRC_DMA : SRC_MD;
      starve_cnt <= starve_next;
      bubble     <= !long_gnt && (bubble || ({29'd0, starve_next} >= STARVE_LIMIT));
      if (bus.wb_reg_write_i && bus.wb_rd_i != '0 && pending[bus.wb_rd_i])
        conflict <= 1'b1;
    end
  end

  core_scoreboard u_scoreboard (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .set_en  (bus.iss_valid_i && bus.iss_rd_i != '0),
    .set_rd  (bus.iss_rd_i),
    .clr_en  (long_gnt),
    .clr_rd  (sel_rd),
    .rs1     (bus.id_rs1_i),
    .rs2     (bus.id_rs2_i),
    .rd      (bus.id_rd_i),
    .pending (pending),
    .hazard  (hazard)
  );

  assign bus.md_ready_o    = (gnt == GNT_MD);
  assign bus.dma_ready_o   = (gnt == GNT_DMA);
  assign bus.rf_we_o       = rf_we;
  assign bus.rf_rd_o       = rf_rd;
  assign bus.rf_din_o      = rf_din;
  assign bus.bubble_req_o  = bubble;
  assign bus.pending_o     = pending;
  assign bus.hazard_o      = hazard;
  assign bus.wb_conflict_o = conflict;
endmodule

// File: tb/tb_core_rf_wb_arbiter.sv
// Directed bench for core_rf_wb_arbiter with hand-computed expectations.
module tb_core_rf_wb_arbiter;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  core_rf_wb_arbiter_if #(.XLEN(32)) bus();

  core_rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.iss_valid_i = 0; bus.iss_src_i = 0; bus.iss_rd_i = 0;
    bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rd_i = 0;
    bus.wb_reg_write_i = 0; bus.wb_rd_i = 0; bus.wb_din_i = 0;
    bus.md_valid_i = 0; bus.md_rd_i = 0; bus.md_din_i = 0;
    bus.dma_valid_i = 0; bus.dma_rd_i = 0; bus.dma_din_i = 0;
    #11;
    check_eq("rst_rf_we", bus.rf_we_o, 0);
    check_eq("rst_rf_rd", bus.rf_rd_o, 0);
    check_eq("rst_rf_din", bus.rf_din_o, 0);
    check_eq("rst_pending", bus.pending_o, 0);
    check_eq("rst_bubble", bus.bubble_req_o, 0);
    check_eq("rst_conflict", bus.wb_conflict_o, 0);
    rst_n = 1'b1;

    // Round-robin: both long-latency sources valid, pointer starts at mul/div
    bus.md_valid_i = 1; bus.md_rd_i = 5'd1; bus.md_din_i = 32'h11;
    bus.dma_valid_i = 1; bus.dma_rd_i = 5'd2; bus.dma_din_i = 32'h22;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_md_ready", bus.md_ready_o, (k % 2 == 0) ? 1 : 0);
      check_eq("rr_dma_ready", bus.dma_ready_o, (k % 2 == 1) ? 1 : 0);
      tick();
      check_eq("rr_rf_rd", bus.rf_rd_o, (k % 2 == 0) ? 1 : 2);
      check_eq("rr_rf_din", bus.rf_din_o, (k % 2 == 0) ? 32'h11 : 32'h22);
      check_eq("rr_rf_we", bus.rf_we_o, 1);
    end
    bus.md_valid_i = 0; bus.dma_valid_i = 0;

    // Issue md to rd=5, RAW hazard, then completion
    bus.iss_valid_i = 1; bus.iss_src_i = 0; bus.iss_rd_i = 5'd5; bus.id_rs1_i = 5'd5;
    #1;
    check_eq("haz_same_cycle", bus.hazard_o, 0);
    tick();
    bus.iss_valid_i = 0;
    check_eq("iss5_pending", bus.pending_o, 32'h20);
    check_eq("iss5_hazard", bus.hazard_o, 1);
    bus.md_valid_i = 1; bus.md_rd_i = 5'd5; bus.md_din_i = 32'h1234;
    #1;
    check_eq("md5_ready", bus.md_ready_o, 1);
    check_eq("md5_hazard_nobypass", bus.hazard_o, 1);
    tick();
    bus.md_valid_i = 0; bus.id_rs1_i = 0;
    check_eq("md5_rf_we", bus.rf_we_o, 1);
    check_eq("md5_rf_rd", bus.rf_rd_o, 5);
    check_eq("md5_rf_din", bus.rf_din_o, 32'h1234);
    check_eq("md5_pending", bus.pending_o, 0);
    bus.id_rs1_i = 5'd5;
    #1;
    check_eq("md5_hazard_clr", bus.hazard_o, 0);
    bus.id_rs1_i = 0;

    // Starvation: wb held while md waits
    bus.wb_reg_write_i = 1; bus.wb_rd_i = 5'd3; bus.wb_din_i = 32'hAA;
    bus.md_valid_i = 1; bus.md_rd_i = 5'd4; bus.md_din_i = 32'h44;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("stv_md_blocked", bus.md_ready_o, 0);
      check_eq("stv_bubble_low", bus.bubble_req_o, 0);
      tick();
    end
    check_eq("stv_bubble_high", bus.bubble_req_o, 1);
    check_eq("stv_wb_rf_rd", bus.rf_rd_o, 3);
    check_eq("stv_wb_rf_din", bus.rf_din_o, 32'hAA);
    bus.wb_reg_write_i = 0;
    #1;
    check_eq("stv_md_granted", bus.md_ready_o, 1);
    tick();
    bus.md_valid_i = 0;
    check_eq("stv_bubble_clr", bus.bubble_req_o, 0);
    check_eq("stv_md_rf_rd", bus.rf_rd_o, 4);

    // Set-wins on same-cycle issue/complete, rd=0 handling
    bus.iss_valid_i = 1; bus.iss_rd_i = 5'd7;
    tick();
    check_eq("iss7_pending", bus.pending_o, 32'h80);
    bus.md_valid_i = 1; bus.md_rd_i = 5'd7; bus.md_din_i = 32'h77;
    tick();
    bus.md_valid_i = 0;
    check_eq("setwins_pending", bus.pending_o, 32'h80);
    bus.iss_rd_i = 5'd0;
    tick();
    bus.iss_valid_i = 0;
    check_eq("iss0_pending", bus.pending_o, 32'h80);
    bus.id_rd_i = 5'd7;
    bus.dma_valid_i = 1; bus.dma_rd_i = 5'd0; bus.dma_din_i = 32'hDD;
    #1;
    check_eq("waw_hazard", bus.hazard_o, 1);
    check_eq("dma0_ready", bus.dma_ready_o, 1);
    tick();
    bus.dma_valid_i = 0; bus.id_rd_i = 0;
    check_eq("dma0_rf_we", bus.rf_we_o, 0);

    // Sticky wb conflict
    bus.iss_valid_i = 1; bus.iss_rd_i = 5'd9;
    tick();
    bus.iss_valid_i = 0;
    check_eq("iss9_pending", bus.pending_o, 32'h280);
    check_eq("pre_conflict", bus.wb_conflict_o, 0);
    bus.wb_reg_write_i = 1; bus.wb_rd_i = 5'd9; bus.wb_din_i = 32'h99;
    tick();
    bus.wb_reg_write_i = 0;
    check_eq("conflict_set", bus.wb_conflict_o, 1);
    check_eq("wb9_rf_rd", bus.rf_rd_o, 9);
    bus.md_valid_i = 1; bus.md_rd_i = 5'd9; bus.md_din_i = 32'h9;
    bus.iss_valid_i = 1; bus.iss_rd_i = 5'd5;
    tick();
    bus.md_valid_i = 0; bus.iss_valid_i = 0;
    check_eq("pend_a0", bus.pending_o, 32'hA0);
    tick();
    tick();
    check_eq("conflict_sticky", bus.wb_conflict_o, 1);

    // Asynchronous reset mid-handshake
    bus.id_rs1_i = 5'd5;
    bus.md_valid_i = 1; bus.md_rd_i = 5'd7; bus.md_din_i = 32'h77;
    #1;
    check_eq("pre_rst_ready", bus.md_ready_o, 1);
    check_eq("pre_rst_hazard", bus.hazard_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rf_we", bus.rf_we_o, 0);
    check_eq("arst_rf_rd", bus.rf_rd_o, 0);
    check_eq("arst_rf_din", bus.rf_din_o, 0);
    check_eq("arst_pending", bus.pending_o, 0);
    check_eq("arst_bubble", bus.bubble_req_o, 0);
    check_eq("arst_conflict", bus.wb_conflict_o, 0);
    check_eq("arst_md_ready", bus.md_ready_o, 0);
    check_eq("arst_hazard", bus.hazard_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_rf_wb_arbiter.md
Name: core_rf_wb_arbiter

Overview:
- Shares the single register-file write port between three sources:
  - in-order pipeline writeback;
  - multi-cycle mul/div results;
  - DMA completions.
- Keeps a 32-entry pending-write scoreboard for long-latency destinations, and raises the decode-stage hazard stall on RAW/WAW against them.
- Sits between the ID stage and the register file. Drives the register file's rd, rd_din and reg_write inputs.

Parameters:
- XLEN, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles a long-latency source may be blocked by pipeline writeback before a bubble is requested (1..7).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- iss_valid_i  in  1  ID issues a long-latency op this cycle
- iss_src_i  in  1  0 = mul/div, 1 = DMA
- iss_rd_i  in  5  destination of the issued op
- id_rs1_i  in  5  decoding instruction rs1
- id_rs2_i  in  5  decoding instruction rs2
- id_rd_i  in  5  decoding instruction rd
- hazard_o  out  1  stall ID: operand or destination pending
- wb_reg_write_i  in  1  pipeline writeback request
- wb_rd_i  in  5  pipeline writeback rd
- wb_din_i  in  XLEN  pipeline writeback data
- md_valid_i  in  1  mul/div result valid
- md_rd_i  in  5  mul/div result rd
- md_din_i  in  XLEN  mul/div result data
- md_ready_o  out  1  mul/div result accepted
- dma_valid_i  in  1  DMA result valid
- dma_rd_i  in  5  DMA result rd
- dma_din_i  in  XLEN  DMA result data
- dma_ready_o  out  1  DMA result accepted
- rf_we_o  out  1  register-file write enable
- rf_rd_o  out  5  register-file write address
- rf_din_o  out  XLEN  register-file write data
- bubble_req_o  out  1  request one pipeline bubble (starvation relief)
- pending_o  out  32  scoreboard contents
- wb_conflict_o  out  1  sticky error: pipeline wrote a pending rd

Behaviour:
- Reset (async, rst_ni=0):
  - rf_we_o=0, rf_rd_o=0, rf_din_o=0.
  - pending_o=0, bubble_req_o=0, wb_conflict_o=0.
  - Round-robin pointer set to mul/div; starvation counter cleared.
  - Reset mid-transfer drops any in-flight grant. Sources re-present after reset.
- Grant priority, combinational, each cycle:
  - wb_reg_write_i=1 always wins; it is never stalled.
  - Otherwise mul/div vs DMA is round-robin. The pointer moves to the other source after each long-latency grant.
  - A lone valid source wins regardless of the pointer.
- Handshakes:
  - md_ready_o = md_valid_i & md granted; dma_ready_o likewise.
  - A transfer completes on valid&ready at the rising edge. The source holds rd and data stable until ready.
- Write port: registered, latency 1.
  - The granted source's rd/data/we appear on rf_*_o the cycle after the grant.
  - rf_we_o is forced to 0 when the granted rd=0; the handshake still completes.
- Scoreboard:
  - iss_valid_i with iss_rd_i!=0 sets pending[iss_rd_i].
  - A long-latency accept clears pending[rd].
  - Simultaneous set and clear of the same rd: set wins.
  - Bit 0 is always 0.
- hazard_o:
  - Combinational from the registered pending vector: pending[id_rs1_i] | pending[id_rs2_i] | pending[id_rd_i].
  - No bypass of same-cycle clears.
- wb_conflict_o: set when wb_reg_write_i=1, wb_rd_i!=0 and pending[wb_rd_i]=1. Cleared only by reset.
- Starvation:
  - A 3-bit counter increments each cycle any long-latency valid is blocked by wb; it clears on any long-latency grant.
  - When the counter reaches STARVE_LIMIT, bubble_req_o=1 (registered) until the next long-latency grant.
  - The pipeline must deassert wb_reg_write_i for at least one cycle in response.
- Long-latency results arriving for a non-pending rd are accepted and written without error.

Decomposition:
- core_pkg holds:
  - src_e enum (SRC_MD=0, SRC_DMA=1);
  - grant_e enum (GNT_NONE, GNT_WB, GNT_MD, GNT_DMA);
  - localparam NUM_REGS=32.
- One natural sub-module: core_scoreboard, which owns the pending vector, the set/clear rules and the hazard lookup.
- The arbiter, write-port register and starvation counter stay in the top module.

Test Plan:
- Issue md to rd=5; ID presents rs1=5 -> hazard_o=1 from the next cycle. md_valid with rd=5, data=0x1234 -> md_ready_o=1, rf_we_o=1/rd=5/din=0x1234 one cycle later, pending[5]=0, hazard_o=0.
- md_valid and dma_valid held together, no wb, for 4 cycles -> grants alternate md, dma, md, dma (pointer starts md after reset).
- wb_reg_write_i held 1 while md_valid=1, STARVE_LIMIT=4 -> bubble_req_o=1 on cycle 5. wb drops for 1 cycle -> md granted, bubble_req_o=0 next cycle.
- Issue to rd=7 in the same cycle md completes rd=7 -> pending[7] stays 1. Issue to rd=0 -> pending stays 0. dma result to rd=0 -> dma_ready_o=1, rf_we_o=0.
- wb write to rd=9 while pending[9]=1 -> wb_conflict_o=1, stays 1 until reset.
- Assert rst_ni=0 mid-handshake with pending=0x0000_00A0 -> all outputs 0 immediately (asynchronous).
